axis_pkt_gen: RTL
=================

Name: axis_pkt_gen

Overview:
AXI-Stream packet transmitter (master) that generates byte-wide test frames into the s_axis side of the stream FIFO.
- On a start request it emits a burst of pkt_num packets, each pkt_len beats long, separated by a programmable idle gap.
- Payload is a deterministic incrementing pattern, so the receiving end can check it.
- Fully honours tready back-pressure.

Parameters:
- GAP_CYCLES, 2, idle cycles (tvalid low) inserted after each packet's last beat; 0 allowed.
- CNT_W, 16, width of the pkts_sent status counter.

Ports:
- axis_clk  in  1  clock, all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a burst; sampled only in IDLE
- pkt_len  in  8  beats per packet; latched at start
- pkt_num  in  8  packets per burst; latched at start
- seed  in  8  payload base value; latched at start
- m_axis_tready  in  1  downstream ready
- m_axis_tvalid  out  1  beat valid
- m_axis_tdata  out  8  beat payload
- m_axis_tkeep  out  1  byte-enable, 1 whenever tvalid=1
- m_axis_tlast  out  1  final beat of packet
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when burst completes
- pkts_sent  out  CNT_W  packets fully accepted since reset, wraps at 2^CNT_W

Behaviour:
- Reset (resetn=0, async): state=IDLE; m_axis_tvalid, tdata, tkeep, tlast, busy, done = 0; pkts_sent=0; internal beat, packet and gap counters = 0.
- All outputs registered.
- States: IDLE, SEND, GAP, FIN.
- IDLE:
  - start=1 with pkt_len!=0 and pkt_num!=0: latch len/num/seed, clear beat_idx and pkt_idx, go to SEND, busy=1.
  - start with a zero len or num is dropped: stays IDLE, no done pulse.
  - start in any other state is ignored.
- Latency: start sampled at edge N gives tvalid=1 with the first beat visible after edge N, i.e. in cycle N+1.
- SEND:
  - tvalid=1, tkeep=1.
  - tdata = (seed + pkt_idx + beat_idx) mod 256, 8-bit wrap.
  - tlast = (beat_idx == len-1).
  - A beat transfers only when tvalid&&tready at a rising edge; beat_idx then increments.
  - While tvalid=1 and tready=0, tdata, tkeep and tlast hold stable. tvalid is never withdrawn before acceptance.
- Last beat accepted:
  - pkts_sent increments and pkt_idx increments.
  - If pkt_idx+1 == num, go to FIN.
  - Else go to GAP (GAP_CYCLES>0) or straight back to SEND with beat_idx=0 (GAP_CYCLES=0). The next beat then presents in the following cycle, so back-to-back packets are allowed.
- GAP: tvalid=0, tlast=0; stays exactly GAP_CYCLES cycles, then returns to SEND with beat_idx=0.
- FIN:
  - Entered after the last accepted beat of the final packet, regardless of GAP_CYCLES; no gap follows the final packet.
  - tvalid=0, busy=0, done=1 for exactly one cycle, then IDLE.
  - A start arriving while in FIN is ignored; a start is accepted from the first IDLE cycle onward.
- pkt_len=1: every beat has tlast=1.
- pkt_len=255 / pkt_num=255: counters sized so there is no overflow (beat and packet counters 8 bits, compared against latched len-1 / num-1).
- Inputs pkt_len, pkt_num and seed may change mid-burst with no effect; only the latched copies are used.
- Reset mid-burst: everything clears immediately (async). No partial tlast is emitted, and pkts_sent counts only completed packets.
- tready toggling in any state other than SEND has no effect.

Test Plan:
1. Reset, then start with len=4, num=1, seed=0x10, tready=1 -> tdata 0x10,0x11,0x12,0x13 on 4 consecutive cycles; tlast only on 0x13; done pulses once; pkts_sent=1.
2. len=3, num=3, seed=0xFE, GAP_CYCLES=2, tready=1 -> packets FE,FF,00 / FF,00,01 / 00,01,02, each followed by 2 tvalid-low cycles except the last; pkts_sent=3; busy low on the done cycle.
3. len=5, num=1, tready held 0 for 3 cycles on beat 2 -> beat 2 tdata/tlast stable and tvalid=1 throughout; all 5 beats delivered in order with no duplicates.
4. len=1, num=4, GAP_CYCLES=0, tready=1 -> 4 single-beat packets on consecutive cycles, each with tlast=1; start pulsed mid-burst is ignored.
5. start with len=0 or num=0 -> tvalid stays 0, busy stays 0, no done pulse.
6. Assert resetn=0 asynchronously mid-packet 2 of 3 -> all outputs 0 immediately; pkts_sent=0 after reset; a subsequent start runs a clean burst.

Source files
------------

// File: rtl/axis_pkt_gen.sv
// AXI-Stream byte-wide test-frame generator.
// On start, emits pkt_num packets of pkt_len beats. Each beat carries
// (seed + pkt_idx + beat_idx) mod 256. Packets are separated by GAP_CYCLES
// idle cycles, and tready back-pressure is fully honoured. All outputs are
// registered.
module axis_pkt_gen #(
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 16
) (
  input  logic             axis_clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [7:0]       pkt_len,
  input  logic [7:0]       pkt_num,
  input  logic [7:0]       seed,
  input  logic             m_axis_tready,
  output logic             m_axis_tvalid,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tkeep,
  output logic             m_axis_tlast,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pkts_sent
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_FIN
  } state_t;

  state_t             r_state;
  logic [7:0]         r_len;
  logic [7:0]         r_num;
  logic [7:0]         r_seed;
  logic [7:0]         r_beat_idx;
  logic [7:0]         r_pkt_idx;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic               r_tvalid;
  logic [7:0]         r_tdata;
  logic               r_tkeep;
  logic               r_tlast;
  logic               r_busy;
  logic               r_done;
  logic [CNT_W-1:0]   r_pkts_sent;

  logic               w_start_ok;
  logic               w_accept;
  logic               w_last_beat;
  logic               w_last_pkt;
  logic [7:0]         w_beat_nxt;
  logic [7:0]         w_pkt_nxt;
  logic [7:0]         w_data_same_pkt;
  logic [7:0]         w_data_next_pkt;
  logic [7:0]         w_data_after_gap;
  logic               w_single_beat;

  assign w_start_ok       = start && (pkt_len != 8'd0) && (pkt_num != 8'd0);
  assign w_accept         = r_tvalid && m_axis_tready;
  assign w_last_beat      = (r_beat_idx == r_len - 8'd1);
  assign w_last_pkt       = (r_pkt_idx == r_num - 8'd1);
  assign w_beat_nxt       = r_beat_idx + 8'd1;
  assign w_pkt_nxt        = r_pkt_idx + 8'd1;
  assign w_data_same_pkt  = r_seed + r_pkt_idx + w_beat_nxt;
  // From SEND the packet index has not advanced yet; in GAP it already has.
  assign w_data_next_pkt  = r_seed + w_pkt_nxt;
  assign w_data_after_gap = r_seed + r_pkt_idx;
  assign w_single_beat    = (r_len == 8'd1);

  // Burst sequencer: state, counters and the registered stream outputs.
  always_ff @(posedge axis_clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_num       <= '0;
      r_seed      <= '0;
      r_beat_idx  <= '0;
      r_pkt_idx   <= '0;
      r_gap_cnt   <= '0;
      r_tvalid    <= 1'b0;
      r_tdata     <= '0;
      r_tkeep     <= 1'b0;
      r_tlast     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pkts_sent <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_len      <= pkt_len;
            r_num      <= pkt_num;
            r_seed     <= seed;
            r_beat_idx <= '0;
            r_pkt_idx  <= '0;
            r_gap_cnt  <= '0;
            r_tvalid   <= 1'b1;
            r_tkeep    <= 1'b1;
            r_tdata    <= seed;
            r_tlast    <= (pkt_len == 8'd1);
            r_busy     <= 1'b1;
            r_state    <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (w_accept) begin
            if (w_last_beat) begin
              r_pkts_sent <= r_pkts_sent + CNT_W'(1);
              r_pkt_idx   <= w_pkt_nxt;
              r_beat_idx  <= '0;
              if (w_last_pkt) begin
                r_tvalid <= 1'b0;
                r_tkeep  <= 1'b0;
                r_tlast  <= 1'b0;
                r_busy   <= 1'b0;
                r_done   <= 1'b1;
                r_state  <= ST_FIN;
              end else if (GAP_CYCLES == 0) begin
                r_tdata <= w_data_next_pkt;
                r_tlast <= w_single_beat;
              end else begin
                r_tvalid  <= 1'b0;
                r_tkeep   <= 1'b0;
                r_tlast   <= 1'b0;
                r_gap_cnt <= '0;
                r_state   <= ST_GAP;
              end
            end else begin
              r_beat_idx <= w_beat_nxt;
              r_tdata    <= w_data_same_pkt;
              r_tlast    <= (w_beat_nxt == r_len - 8'd1);
            end
          end
        end

        ST_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_gap_cnt <= '0;
            r_tvalid  <= 1'b1;
            r_tkeep   <= 1'b1;
            r_tdata   <= w_data_after_gap;
            r_tlast   <= w_single_beat;
            r_state   <= ST_SEND;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end

        ST_FIN: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tkeep  = r_tkeep;
  assign m_axis_tlast  = r_tlast;
  assign busy          = r_busy;
  assign done          = r_done;
  assign pkts_sent     = r_pkts_sent;

endmodule
